// File: rtl/updown_counter_ctrl.sv
// Button debounce + STOP/RUN/CLEAR control for the 0..9999 up/down counter.
// Optional end-of-range auto stop is enabled with `define UPDOWN_AUTO_STOP_EN.
module updown_btn_db #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1, sync2, deb, deb_d1;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles where the synced level disagrees with deb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      deb_d1 <= 1'b0;
      pulse  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      deb_d1 <= deb;
      pulse  <= deb & ~deb_d1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module updown_counter_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 14,
  parameter int CNT_MAX      = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_clear,
  input  logic             btn_mode,
  input  logic [CNT_W-1:0] count,
  output logic             run_en,
  output logic             clear,
  output logic             mode,
  output logic [1:0]       state
);
  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b10;

  logic [2:0] btns, pulses;
  logic       run_p, clear_p, mode_p, at_end;
  logic [1:0] nxt_state;
  logic       nxt_mode;

  assign btns = {btn_mode, btn_clear, btn_run};

  updown_btn_db #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db [2:0] (
    .clk   (clk),
    .rst   (rst),
    .btn   (btns),
    .pulse (pulses)
  );

  assign run_p   = pulses[0];
  assign clear_p = pulses[1];
  assign mode_p  = pulses[2];

`ifdef UPDOWN_AUTO_STOP_EN
  localparam logic [CNT_W-1:0] END_UP = CNT_W'(CNT_MAX);
  logic [CNT_W-1:0] count_d1, end_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_d1 <= '0;
    else     count_d1 <= count;
  end

  // Stop only on arrival at the end value, so starting a run parked there is allowed
  assign end_val = mode ? '0 : END_UP;
  assign at_end  = (count == end_val) && (count_d1 != end_val);
`else
  logic unused_count;
  assign unused_count = ^count;
  assign at_end       = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_mode  = mode;
    case (state)
      ST_STOP: begin
        if (clear_p)    nxt_state = ST_CLEAR;
        else if (run_p) nxt_state = ST_RUN;
        if (mode_p)     nxt_mode  = ~mode;
      end
      ST_RUN: begin
        if (clear_p)     nxt_state = ST_CLEAR;
        else if (run_p)  nxt_state = ST_STOP;
        else if (at_end) nxt_state = ST_STOP;
      end
      ST_CLEAR: nxt_state = ST_STOP;
      default:  nxt_state = ST_STOP;
    endcase
  end

  // Outputs decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_STOP;
      run_en <= 1'b0;
      clear  <= 1'b0;
      mode   <= 1'b0;
    end else begin
      state  <= nxt_state;
      run_en <= (nxt_state == ST_RUN);
      clear  <= (nxt_state == ST_CLEAR);
      mode   <= nxt_mode;
    end
  end
endmodule
